// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: prediction/resolution payloads and resolver FSM states.
package branch_resolver_pkg;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] target;
    } prediction_t;

    typedef struct packed {
        logic            valid;
        logic            mispredict;
        logic            taken;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } resolution_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } resolver_state_t;

    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/branch_resolver_pred_fifo.sv
// In-order prediction queue with synchronous clear; pointers carry an extra wrap bit.
module pred_fifo
    import branch_resolver_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned PW   = AW + 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clear_i,
    input  logic        push_i,
    input  prediction_t data_i,
    input  logic        pop_i,
    output prediction_t head_c,
    output logic        full_c,
    output logic        empty_c,
    output logic [PW-1:0] count_c
);

    prediction_t     mem_q [DEPTH];
    prediction_t     mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            push_ok;
    logic            pop_ok;

    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign count_c = wr_ptr_q - rd_ptr_q;
    assign head_c  = mem_q[rd_ptr_q[AW-1:0]];
    assign push_ok = push_i & ~full_c;
    assign pop_ok  = pop_i & ~empty_c;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q[AW-1:0]] = data_i;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset; pointers alone define validity.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves executed branches against queued predictions, drives bpu updates and front-end redirects.
// Optional resolved/mispredict statistics counters under `BRANCH_RESOLVER_STATS_EN.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned RECOVER_CYCLES = 2,
    localparam int unsigned CW            = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            pred_valid_i,
    input  prediction_t     pred_i,
    output logic            pred_ready_o,
    input  logic            exec_valid_i,
    input  logic [XLEN-1:0] exec_pc_i,
    input  logic            exec_taken_i,
    input  logic [XLEN-1:0] exec_target_i,
    output logic            exec_ready_o,
    output resolution_t     res_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [CW-1:0]   count_o,
    output logic [31:0]     stat_branches_o,
    output logic [31:0]     stat_mispred_o
);

    localparam int unsigned RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    resolver_state_t state_q, state_d;
    logic [RW-1:0]   rec_cnt_q, rec_cnt_d;
    resolution_t     res_q, res_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    prediction_t     head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop_fire;
    logic            mispredict_c;
    logic            mis_fire;
    logic            push_fire;
    logic            fifo_clear;
    logic [XLEN-1:0] correct_pc;
    logic            unused_head_pc;

    assign pred_ready_o = !fifo_full && (state_q == RUN) && !flush_i;
    assign exec_ready_o = !fifo_empty && (state_q == RUN);

    // Flush overrides any handshake seen in the same cycle.
    assign pop_fire     = exec_valid_i & exec_ready_o & ~flush_i;
    assign mispredict_c = (head.taken != exec_taken_i) |
                          (exec_taken_i & (head.target != exec_target_i));
    assign mis_fire     = pop_fire & mispredict_c;
    assign push_fire    = pred_valid_i & pred_ready_o & ~mis_fire;
    assign fifo_clear   = flush_i | mis_fire;
    assign correct_pc   = exec_taken_i ? exec_target_i : next_seq_pc(exec_pc_i);

    // Ordering is guaranteed by execute, so the stored PC is not re-checked.
    assign unused_head_pc = ^head.pc;

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (fifo_clear),
        .push_i  (push_fire),
        .data_i  (pred_i),
        .pop_i   (pop_fire),
        .head_c  (head),
        .full_c  (fifo_full),
        .empty_c (fifo_empty),
        .count_c (count_o)
    );

    always_comb begin
        state_d       = state_q;
        rec_cnt_d     = rec_cnt_q;
        res_d         = '0;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;

        if (pop_fire) begin
            res_d.valid      = 1'b1;
            res_d.mispredict = mispredict_c;
            res_d.taken      = exec_taken_i;
            res_d.pc         = exec_pc_i;
            res_d.target     = exec_target_i;
        end
        if (mis_fire) begin
            redirect_d    = 1'b1;
            redirect_pc_d = correct_pc;
        end

        case (state_q)
            RUN: begin
                if (mis_fire) begin
                    state_d   = RECOVER;
                    rec_cnt_d = RW'(RECOVER_CYCLES - 1);
                end
            end
            RECOVER: begin
                if (rec_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    rec_cnt_d = rec_cnt_q - RW'(1);
                end
            end
        endcase

        if (flush_i) begin
            state_d   = RUN;
            rec_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= RUN;
            rec_cnt_q     <= '0;
            res_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            rec_cnt_q     <= rec_cnt_d;
            res_q         <= res_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign res_o         = res_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    // Survive flush; only reset clears them.
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (pop_fire) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (mis_fire) begin
            stat_mp_d = stat_mp_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches_o = stat_br_q;
    assign stat_mispred_o  = stat_mp_q;
`else
    assign stat_branches_o = 32'd0;
    assign stat_mispred_o  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed test-plan cases followed by randomized phases.
module tb_branch_resolver;
    import branch_resolver_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned RC    = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            pred_valid;
    prediction_t     pred;
    logic            pred_ready;
    logic            exec_valid;
    logic [XLEN-1:0] exec_pc;
    logic            exec_taken;
    logic [XLEN-1:0] exec_target;
    logic            exec_ready;
    resolution_t     res;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [CW-1:0]   count;
    logic [31:0]     stat_br;
    logic [31:0]     stat_mp;

    branch_resolver #(
        .DEPTH          (DEPTH),
        .RECOVER_CYCLES (RC)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .flush_i         (flush),
        .pred_valid_i    (pred_valid),
        .pred_i          (pred),
        .pred_ready_o    (pred_ready),
        .exec_valid_i    (exec_valid),
        .exec_pc_i       (exec_pc),
        .exec_taken_i    (exec_taken),
        .exec_target_i   (exec_target),
        .exec_ready_o    (exec_ready),
        .res_o           (res),
        .redirect_o      (redirect),
        .redirect_pc_o   (redirect_pc),
        .count_o         (count),
        .stat_branches_o (stat_br),
        .stat_mispred_o  (stat_mp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            mis;
        logic            taken;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] next_pc;
        int              due;
    } exp_t;

    // Reference model: queue contents, blocked-cycle budget, statistics.
    prediction_t m_q[$];
    int          m_block;
    int unsigned m_br;
    int unsigned m_mp;
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          cycle = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: every res_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (res.valid) begin
            if (exp_q.size() == 0) begin
                chk("res_unexpected", 64'(res.valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_mispredict", 64'(res.mispredict), 64'(mon_e.mis));
                chk("res_taken", 64'(res.taken), 64'(mon_e.taken));
                chk("res_pc", 64'(res.pc), 64'(mon_e.pc));
                chk("res_target", 64'(res.target), 64'(mon_e.target));
                chk("redirect", 64'(redirect), 64'(mon_e.mis));
                if (mon_e.mis) chk("redirect_pc", 64'(redirect_pc), 64'(mon_e.next_pc));
            end
        end else begin
            chk("redirect_idle", 64'(redirect), 64'd0);
            if (exp_q.size() > 0 && exp_q[0].due < cycle) begin
                mon_e = exp_q.pop_front();
                chk("res_missing", 64'd0, 64'd1);
            end
        end
    end

    function automatic logic [31:0] exp_stat(input int unsigned v);
`ifdef BRANCH_RESOLVER_STATS_EN
        return 32'(v);
`else
        return 32'(v & 0);
`endif
    endfunction

    // One clock of stimulus; checks handshake outputs and advances the model.
    task automatic cyc(input logic fl, input logic pv, input prediction_t p,
                       input logic ev, input logic [XLEN-1:0] epc,
                       input logic et, input logic [XLEN-1:0] etg);
        logic        rdy_push, rdy_exec, do_push, do_pop, mis;
        prediction_t h;
        exp_t        e;
        @(posedge clk); #1;
        flush = fl; pred_valid = pv; pred = p;
        exec_valid = ev; exec_pc = epc; exec_taken = et; exec_target = etg;
        #1;
        rdy_push = (m_q.size() < DEPTH) && (m_block == 0) && !fl;
        rdy_exec = (m_q.size() > 0) && (m_block == 0);
        chk("pred_ready", 64'(pred_ready), 64'(rdy_push));
        chk("exec_ready", 64'(exec_ready), 64'(rdy_exec));
        chk("count", 64'(count), 64'(m_q.size()));
        chk("stat_branches", 64'(stat_br), 64'(exp_stat(m_br)));
        chk("stat_mispred", 64'(stat_mp), 64'(exp_stat(m_mp)));
        do_push = pv && rdy_push;
        do_pop  = ev && rdy_exec && !fl;
        mis     = 1'b0;
        if (do_pop) begin
            h   = m_q[0];
            mis = (h.taken != et) || (et && (h.target != etg));
            e.mis = mis; e.taken = et; e.pc = epc; e.target = etg;
            e.next_pc = et ? etg : XLEN'(epc + 32'd4);
            e.due = cycle + 1;
            exp_q.push_back(e);
            m_br++;
            if (mis) m_mp++;
        end
        if (fl) begin
            m_q.delete();
            m_block = 0;
        end else if (do_pop && mis) begin
            m_q.delete();
            m_block = RC;
        end else begin
            if (m_block > 0) m_block--;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(p);
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic push(input logic [XLEN-1:0] pc, input logic tk, input logic [XLEN-1:0] tg);
        prediction_t p;
        p.pc = pc; p.taken = tk; p.target = tg;
        cyc(1'b0, 1'b1, p, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        flush = 1'b0; pred_valid = 1'b0; exec_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_q.delete(); m_block = 0; m_br = 0; m_mp = 0;
        chk("rst_res_zero", 64'(res == '0), 64'd1);
        chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_stat_br", 64'(stat_br), 64'd0);
    endtask

    // Random cycle: exec follows the model head, with a chosen mispredict rate.
    task automatic rnd_cyc(input int push_pct, input int exec_pct, input int mis_pct, input int fl_pct);
        prediction_t     p;
        logic            fl, pv, ev, et;
        logic [XLEN-1:0] epc, etg;
        fl = ($urandom_range(99) < fl_pct);
        pv = ($urandom_range(99) < push_pct);
        ev = ($urandom_range(99) < exec_pct);
        p.pc     = XLEN'($urandom) & ~32'h3;
        p.taken  = 1'($urandom);
        p.target = XLEN'($urandom) & ~32'h3;
        epc = XLEN'($urandom); et = 1'($urandom); etg = XLEN'($urandom);
        if (m_q.size() > 0) begin
            epc = m_q[0].pc;
            if ($urandom_range(99) < mis_pct) begin
                if (m_q[0].taken && $urandom_range(1) == 0) begin
                    et = 1'b1; etg = m_q[0].target ^ 32'h10;
                end else begin
                    et = ~m_q[0].taken; etg = XLEN'($urandom) & ~32'h3;
                end
            end else begin
                et  = m_q[0].taken;
                etg = m_q[0].taken ? m_q[0].target : XLEN'($urandom);
            end
        end
        cyc(fl, pv, p, ev, epc, et, etg);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; pred_valid = 1'b0; pred = '0;
        exec_valid = 1'b0; exec_pc = '0; exec_taken = 1'b0; exec_target = '0;
        m_block = 0; m_br = 0; m_mp = 0;
        do_reset();

        // Correct taken prediction.
        push(32'h100, 1'b1, 32'h200);
        cyc(1'b0, 1'b0, '0, 1'b1, 32'h100, 1'b1, 32'h200);
        idle();

        // Direction mispredict; two blocked cycles follow.
        push(32'h100, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, '0, 1'b1, 32'h100, 1'b1, 32'h180);
        push(32'h300, 1'b0, 32'h0);
        push(32'h304, 1'b0, 32'h0);
        push(32'h308, 1'b0, 32'h0);
        idle();

        // Head not-taken outcome with same-cycle push dropped.
        do_reset();
        push(32'h40, 1'b1, 32'h80);
        push(32'h44, 1'b0, 32'h0);
        push(32'h48, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, '{pc: 32'h900, taken: 1'b0, target: 32'h0}, 1'b1, 32'h40, 1'b0, 32'h0);
        repeat (3) idle();

        // Fill to full, then alternate pop/push across pointer wrap.
        for (int i = 0; i < 9; i++) push(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) cyc(1'b0, 1'b0, '0, 1'b1, m_q[0].pc, 1'b0, 32'h0);
            else push(32'h2000 + 32'(i * 4), 1'b0, 32'h0);
        end

        // Flush with four queued entries and a concurrent pop.
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h500 + 32'(i * 4), 1'b0, 32'h0);
        cyc(1'b1, 1'b1, '{pc: 32'h600, taken: 1'b0, target: 32'h0}, 1'b1, 32'h500, 1'b0, 32'h0);
        repeat (2) idle();

        // Five pops with two mispredicts, then a flush that must not clear stats.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(32'h700 + 32'(i * 4), 1'b1, 32'h800);
            cyc(1'b0, 1'b0, '0, 1'b1, 32'h700 + 32'(i * 4), (i % 2 == 1) ? 1'b0 : 1'b1, 32'h800);
            repeat (2) idle();
        end
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        idle();

        // Randomized phases: balanced, fill-heavy, drain-heavy, flush-heavy.
        for (int i = 0; i < 600; i++) rnd_cyc(50, 50, 20, 2);
        for (int i = 0; i < 300; i++) rnd_cyc(90, 15, 5, 0);
        for (int i = 0; i < 300; i++) rnd_cyc(30, 90, 30, 1);
        do_reset();
        for (int i = 0; i < 300; i++) rnd_cyc(70, 70, 10, 10);
        for (int i = 0; i < 200; i++) begin
            if (i == 100) do_reset();
            rnd_cyc(60, 60, 25, 3);
        end

        repeat (4) idle();
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
